// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read ports, write port, reserve port and status.
interface regfile_scoreboard_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 5
);
  logic [ADDR_W-1:0] SA;
  logic [ADDR_W-1:0] SB;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [ADDR_W-1:0] DA;
  logic [WIDTH-1:0]  D;
  logic              W;
  logic [ADDR_W-1:0] RA;
  logic              RV;
  logic              A_ready;
  logic              B_ready;
  logic [ADDR_W:0]   busy_count;
  logic              rsv_err;

  modport master (
    output SA, SB, DA, D, W, RA, RV,
    input  A, B, A_ready, B_ready, busy_count, rsv_err
  );

  modport slave (
    input  SA, SB, DA, D, W, RA, RV,
    output A, B, A_ready, B_ready, busy_count, rsv_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy bits for operand readiness tracking.
// Two combinational read ports, one write port, one reservation port.
module regfile_scoreboard #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned       N        = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(N - 1);

  logic [WIDTH-1:0] regs_q [N];
  logic [WIDTH-1:0] regs_d [N];
  logic [N-1:0]     busy_q, busy_d;
  logic [ADDR_W:0]  busy_count_q, busy_count_d;
  logic             rsv_err_q, rsv_err_d;

  logic             da_zero, ra_zero, sa_zero, sb_zero;
  logic             sa_hit, sb_hit;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_rdy, b_rdy;

  // Classify addresses: hardwired-zero register and same-cycle write hits.
  always_comb begin
    da_zero = ZERO_REG && (bus.DA == ZeroAddr);
    ra_zero = ZERO_REG && (bus.RA == ZeroAddr);
    sa_zero = ZERO_REG && (bus.SA == ZeroAddr);
    sb_zero = ZERO_REG && (bus.SB == ZeroAddr);
    sa_hit  = BYPASS && bus.W && (bus.DA == bus.SA);
    sb_hit  = BYPASS && bus.W && (bus.DA == bus.SB);
  end

  // Next-state: write data, clear-on-write then set-on-reserve, popcount of result.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    if (bus.W && !da_zero) begin
      regs_d[bus.DA] = bus.D;
    end
    if (bus.W) begin
      busy_d[bus.DA] = 1'b0;
    end
    // Reserve is applied after the write clear so it wins on a matching address.
    if (bus.RV && !ra_zero) begin
      busy_d[bus.RA] = 1'b1;
      rsv_err_d      = busy_q[bus.RA] && !(bus.W && (bus.DA == bus.RA));
    end
    busy_count_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // State registers with synchronous reset that overrides write and reserve.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
      rsv_err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      rsv_err_q    <= rsv_err_d;
    end
  end

  // Read ports with optional write bypass; zero register always reads 0 and is always ready.
  always_comb begin
    a_data = regs_q[bus.SA];
    b_data = regs_q[bus.SB];
    if (sa_hit && !da_zero) a_data = bus.D;
    if (sb_hit && !da_zero) b_data = bus.D;
    if (sa_zero) a_data = '0;
    if (sb_zero) b_data = '0;
    a_rdy = !busy_q[bus.SA] || sa_hit || sa_zero;
    b_rdy = !busy_q[bus.SB] || sb_hit || sb_zero;
  end

  assign bus.A          = a_data;
  assign bus.B          = b_data;
  assign bus.A_ready    = a_rdy;
  assign bus.B_ready    = b_rdy;
  assign bus.busy_count = busy_count_q;
  assign bus.rsv_err    = rsv_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: directed scenarios on the default 64-bit build, then a randomized run on two
// 32-bit/16-entry builds (zero reg + bypass, and neither) against a behavioural model.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_scoreboard_if #(.WIDTH(64), .ADDR_W(5)) bus64 ();
  regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(4)) bus_zb ();
  regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(4)) bus_nn ();

  regfile_scoreboard #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut64 (
    .clock (clock),
    .reset (reset),
    .bus   (bus64)
  );

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_zb (
    .clock (clock),
    .reset (reset),
    .bus   (bus_zb)
  );

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_nn (
    .clock (clock),
    .reset (reset),
    .bus   (bus_nn)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock: inputs set before the call are sampled at the next rising edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle64();
    bus64.SA = '0; bus64.SB = '0; bus64.DA = '0; bus64.D = '0;
    bus64.W  = 1'b0; bus64.RA = '0; bus64.RV = 1'b0;
  endtask

  task automatic drive_small(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] da,
                             input logic [31:0] d, input logic w, input logic [3:0] ra,
                             input logic rv);
    bus_zb.SA = sa; bus_zb.SB = sb; bus_zb.DA = da; bus_zb.D = d;
    bus_zb.W  = w;  bus_zb.RA = ra; bus_zb.RV = rv;
    bus_nn.SA = sa; bus_nn.SB = sb; bus_nn.DA = da; bus_nn.D = d;
    bus_nn.W  = w;  bus_nn.RA = ra; bus_nn.RV = rv;
  endtask

  // Every address of the 64-bit build reads 0 and is ready; no pending reservations.
  task automatic check_all_clear64(input string tag);
    idle64();
    #1;
    check_eq({tag, "_count"}, 64'(bus64.busy_count), 64'd0);
    check_eq({tag, "_err"}, 64'(bus64.rsv_err), 64'd0);
    for (int i = 0; i < 32; i++) begin
      bus64.SA = 5'(i);
      bus64.SB = 5'(31 - i);
      #1;
      check_eq($sformatf("%s_A%0d", tag, i), bus64.A, 64'd0);
      check_eq($sformatf("%s_B%0d", tag, i), bus64.B, 64'd0);
      check_eq($sformatf("%s_Ardy%0d", tag, i), 64'(bus64.A_ready), 64'd1);
      check_eq($sformatf("%s_Brdy%0d", tag, i), 64'(bus64.B_ready), 64'd1);
    end
  endtask

  // Behavioural model for the two 32-bit builds: index 0 = zero reg + bypass, 1 = neither.
  logic [31:0] m_regs [2][16];
  bit          m_busy [2][16];
  bit          m_err  [2];

  function automatic logic [31:0] m_read(input int c, input int addr, input bit w,
                                         input int da, input logic [31:0] d);
    bit zr = (c == 0);
    bit by = (c == 0);
    if (zr && addr == 15) return 32'd0;
    if (by && w && da == addr) return d;
    return m_regs[c][addr];
  endfunction

  function automatic bit m_ready(input int c, input int addr, input bit w, input int da);
    bit zr = (c == 0);
    bit by = (c == 0);
    if (zr && addr == 15) return 1'b1;
    if (by && w && da == addr) return 1'b1;
    return !m_busy[c][addr];
  endfunction

  function automatic int m_count(input int c);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[c][i]);
    return n;
  endfunction

  task automatic m_update(input bit rst, input bit w, input int da, input logic [31:0] d,
                          input bit rv, input int ra);
    for (int c = 0; c < 2; c++) begin
      bit zr = (c == 0);
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_regs[c][i] = 32'd0;
          m_busy[c][i] = 1'b0;
        end
        m_err[c] = 1'b0;
      end else begin
        bit ra_ok = rv && !(zr && ra == 15);
        m_err[c] = ra_ok && m_busy[c][ra] && !(w && da == ra);
        if (w && !(zr && da == 15)) m_regs[c][da] = d;
        if (w) m_busy[c][da] = 1'b0;
        if (ra_ok) m_busy[c][ra] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] ga, gb;
    logic        gar, gbr, gerr;
    logic [4:0]  gcnt;

    // Reset everything with write and reserve active, which must be discarded.
    reset = 1'b1;
    idle64();
    bus64.W = 1'b1; bus64.DA = 5'd4; bus64.D = 64'h55; bus64.RV = 1'b1; bus64.RA = 5'd6;
    drive_small(4'd0, 4'd0, 4'd2, 32'h77, 1'b1, 4'd3, 1'b1);
    tick();
    reset = 1'b0;
    drive_small(4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    check_all_clear64("rst");

    // Plain write then read; write to the zero register is ignored.
    idle64();
    bus64.W = 1'b1; bus64.DA = 5'd3; bus64.D = 64'hDEAD_BEEF;
    tick();
    idle64(); bus64.SA = 5'd3;
    #1 check_eq("rd3", bus64.A, 64'hDEAD_BEEF);
    bus64.W = 1'b1; bus64.DA = 5'd31; bus64.D = 64'hFFFF_FFFF;
    tick();
    idle64(); bus64.SA = 5'd31; bus64.SB = 5'd3;
    #1 check_eq("rd31", bus64.A, 64'd0);
    check_eq("rd3_b", bus64.B, 64'hDEAD_BEEF);

    // Bypass: written data visible in the same cycle.
    bus64.W = 1'b1; bus64.DA = 5'd5; bus64.D = 64'h1234; bus64.SA = 5'd5;
    #1 check_eq("byp_A", bus64.A, 64'h1234);
    check_eq("byp_Ardy", 64'(bus64.A_ready), 64'd1);
    tick();
    idle64(); bus64.SA = 5'd5;
    #1 check_eq("byp_after", bus64.A, 64'h1234);

    // No bypass: old value until the edge after the write.
    drive_small(4'd5, 4'd5, 4'd5, 32'h1234, 1'b1, 4'd0, 1'b0);
    #1 check_eq("nobyp_A", 64'(bus_nn.A), 64'd0);
    check_eq("nobyp_Ardy", 64'(bus_nn.A_ready), 64'd1);
    tick();
    drive_small(4'd5, 4'd5, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    #1 check_eq("nobyp_next", 64'(bus_nn.A), 64'h1234);

    // Reserve then write releases the operand.
    idle64(); bus64.RV = 1'b1; bus64.RA = 5'd7;
    tick();
    idle64(); bus64.SA = 5'd7;
    #1 check_eq("rsv7_Ardy", 64'(bus64.A_ready), 64'd0);
    check_eq("rsv7_count", 64'(bus64.busy_count), 64'd1);
    bus64.W = 1'b1; bus64.DA = 5'd7; bus64.D = 64'h7;
    #1 check_eq("wr7_byp_rdy", 64'(bus64.A_ready), 64'd1);
    tick();
    idle64(); bus64.SA = 5'd7;
    #1 check_eq("wr7_Ardy", 64'(bus64.A_ready), 64'd1);
    check_eq("wr7_count", 64'(bus64.busy_count), 64'd0);

    // Double reservation raises a one-cycle error; reserve+write on same address does not.
    idle64(); bus64.RV = 1'b1; bus64.RA = 5'd9;
    tick();
    #1 check_eq("rsv9a_err", 64'(bus64.rsv_err), 64'd0);
    tick();
    #1 check_eq("rsv9b_err", 64'(bus64.rsv_err), 64'd1);
    check_eq("rsv9b_count", 64'(bus64.busy_count), 64'd1);
    idle64();
    tick();
    #1 check_eq("rsv9c_err", 64'(bus64.rsv_err), 64'd0);
    bus64.RV = 1'b1; bus64.RA = 5'd9; bus64.W = 1'b1; bus64.DA = 5'd9; bus64.D = 64'h9;
    tick();
    idle64(); bus64.SA = 5'd9;
    #1 check_eq("rw9_err", 64'(bus64.rsv_err), 64'd0);
    check_eq("rw9_Ardy", 64'(bus64.A_ready), 64'd0);
    check_eq("rw9_count", 64'(bus64.busy_count), 64'd1);
    bus64.W = 1'b1; bus64.DA = 5'd9;
    tick();
    // Reservations of the zero register are ignored.
    idle64(); bus64.RV = 1'b1; bus64.RA = 5'd31;
    tick();
    tick();
    idle64(); bus64.SA = 5'd31;
    #1 check_eq("rsv31_count", 64'(bus64.busy_count), 64'd0);
    check_eq("rsv31_err", 64'(bus64.rsv_err), 64'd0);
    check_eq("rsv31_rdy", 64'(bus64.A_ready), 64'd1);

    // Busy state, then reset with write and reserve (one on a busy register) pending.
    for (int i = 10; i < 14; i++) begin
      idle64(); bus64.RV = 1'b1; bus64.RA = 5'(i);
      tick();
    end
    for (int i = 14; i < 16; i++) begin
      idle64(); bus64.W = 1'b1; bus64.DA = 5'(i); bus64.D = 64'hABCD_0000 + 64'(i);
      tick();
    end
    idle64();
    #1 check_eq("pre_rst_count", 64'(bus64.busy_count), 64'd4);
    reset = 1'b1;
    bus64.W = 1'b1; bus64.DA = 5'd16; bus64.D = 64'h1616; bus64.RV = 1'b1; bus64.RA = 5'd10;
    tick();
    reset = 1'b0;
    check_all_clear64("rst2");

    // Randomized run on both 32-bit builds.
    reset = 1'b1;
    drive_small(4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0);
    m_update(1'b1, 1'b0, 0, 32'd0, 1'b0, 0);
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int          r_sa = int'($urandom_range(0, 15));
      int          r_sb = int'($urandom_range(0, 15));
      int          r_da = int'($urandom_range(0, 15));
      int          r_ra = int'($urandom_range(0, 15));
      logic [31:0] r_d  = $urandom;
      bit          r_w  = ($urandom_range(0, 1) == 1);
      bit          r_rv = ($urandom_range(0, 1) == 1);
      bit          r_rst = ($urandom_range(0, 299) == 0);
      // Bias read addresses toward the write address to exercise bypass.
      if ($urandom_range(0, 3) == 0) r_sa = r_da;
      if ($urandom_range(0, 3) == 0) r_sb = r_da;
      reset = r_rst;
      drive_small(4'(r_sa), 4'(r_sb), 4'(r_da), r_d, r_w, 4'(r_ra), r_rv);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (c == 0) begin
          ga = bus_zb.A; gb = bus_zb.B; gar = bus_zb.A_ready; gbr = bus_zb.B_ready;
          gcnt = bus_zb.busy_count; gerr = bus_zb.rsv_err;
        end else begin
          ga = bus_nn.A; gb = bus_nn.B; gar = bus_nn.A_ready; gbr = bus_nn.B_ready;
          gcnt = bus_nn.busy_count; gerr = bus_nn.rsv_err;
        end
        check_eq($sformatf("rnd%0d_A@%0d", c, cyc), 64'(ga), 64'(m_read(c, r_sa, r_w, r_da, r_d)));
        check_eq($sformatf("rnd%0d_B@%0d", c, cyc), 64'(gb), 64'(m_read(c, r_sb, r_w, r_da, r_d)));
        check_eq($sformatf("rnd%0d_Ardy@%0d", c, cyc), 64'(gar), 64'(m_ready(c, r_sa, r_w, r_da)));
        check_eq($sformatf("rnd%0d_Brdy@%0d", c, cyc), 64'(gbr), 64'(m_ready(c, r_sb, r_w, r_da)));
        check_eq($sformatf("rnd%0d_cnt@%0d", c, cyc), 64'(gcnt), 64'(m_count(c)));
        check_eq($sformatf("rnd%0d_err@%0d", c, cyc), 64'(gerr), 64'(m_err[c]));
      end
      m_update(r_rst, r_w, r_da, r_d, r_rv, r_ra);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
